// File: rtl/soe_monitor.sv
// -----------------------------------------------------------------------------
// soe_monitor
//
// Sum-of-errors monitor placed directly after a design under fault injection.
// On every valid cycle of a run it compares the observed word with the golden
// word under a per-bit mask. It counts:
//   - erroneous samples (soe_total);
//   - per-bit mismatches (soe_bit);
//   - evaluated samples (samples).
// It also records the index of the first erroneous sample. A run covers a
// programmed number of valid samples and ends in DONE, where the results hold
// until the next start.
//
// Ports
//   clk, rst_n    single clock, asynchronous active-low reset
//   start         begins a run (accepted in IDLE or DONE)
//   num_cycles    valid samples to evaluate, latched on start
//   mask          per-bit compare enable, latched on start
//   obs_valid     obs/gold pair valid this cycle
//   obs, gold     observed and golden words, already aligned by the producer
//   abort         ends a run early (RUN only); the sample offered with it
//                 is still evaluated
//   busy, done    state flags (RUN, DONE)
//   soe_total     samples with at least one unmasked mismatch
//   soe_bit       per-bit mismatch counters, bit i at [i*CNT_W +: CNT_W]
//   samples       valid samples evaluated in this run
//   first_err     0-based index of first erroneous sample, all-ones if none
//   err_seen      at least one error seen in this run
// All counters saturate at all-ones.
// -----------------------------------------------------------------------------
module soe_monitor #(
    parameter int WIDTH = 2,
    parameter int CYC_W = 32,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CYC_W-1:0]       num_cycles,
    input  logic [WIDTH-1:0]       mask,
    input  logic                   obs_valid,
    input  logic [WIDTH-1:0]       obs,
    input  logic [WIDTH-1:0]       gold,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       soe_total,
    output logic [WIDTH*CNT_W-1:0] soe_bit,
    output logic [CYC_W-1:0]       samples,
    output logic [CYC_W-1:0]       first_err,
    output logic                   err_seen
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONES = {CYC_W{1'b1}};

    // Saturating increment of an error counter.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    // Saturating increment of the sample counter.
    function automatic logic [CYC_W-1:0] cyc_inc(input logic [CYC_W-1:0] v);
        return (v == CYC_ONES) ? v : v + CYC_ONE;
    endfunction

    state_t             state_r;
    logic [CYC_W-1:0]   num_cycles_r;
    logic [WIDTH-1:0]   mask_r;

    logic [WIDTH-1:0]   err_vec_s;
    logic [CYC_W-1:0]   samples_inc_s;
    logic               last_s;

    // Masked mismatch vector and end-of-run detection for the current sample.
    always_comb begin
        err_vec_s     = (obs ^ gold) & mask_r;
        samples_inc_s = cyc_inc(samples);
        last_s        = (samples_inc_s == num_cycles_r);
    end

    // Run control FSM with the counters and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            num_cycles_r <= CYC_ZERO;
            mask_r       <= {WIDTH{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            soe_total    <= CNT_ZERO;
            soe_bit      <= {(WIDTH*CNT_W){1'b0}};
            samples      <= CYC_ZERO;
            first_err    <= CYC_ONES;
            err_seen     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        num_cycles_r <= num_cycles;
                        mask_r       <= mask;
                        soe_total    <= CNT_ZERO;
                        soe_bit      <= {(WIDTH*CNT_W){1'b0}};
                        samples      <= CYC_ZERO;
                        first_err    <= CYC_ONES;
                        err_seen     <= 1'b0;
                        // A zero-length run completes immediately.
                        if (num_cycles == CYC_ZERO) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (obs_valid) begin
                        samples <= samples_inc_s;
                        if (|err_vec_s) begin
                            soe_total <= cnt_inc(soe_total);
                            for (int i = 0; i < WIDTH; i++) begin
                                if (err_vec_s[i]) begin
                                    soe_bit[i*CNT_W +: CNT_W] <= cnt_inc(soe_bit[i*CNT_W +: CNT_W]);
                                end else begin
                                    soe_bit[i*CNT_W +: CNT_W] <= soe_bit[i*CNT_W +: CNT_W];
                                end
                            end
                            // Pre-increment count is the 0-based sample index.
                            if (!err_seen) begin
                                first_err <= samples;
                                err_seen  <= 1'b1;
                            end else begin
                                first_err <= first_err;
                            end
                        end else begin
                            soe_total <= soe_total;
                        end
                    end else begin
                        samples <= samples;
                    end
                    // Abort wins over completion; the final sample is still counted.
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (obs_valid && last_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soe_monitor.sv
// -----------------------------------------------------------------------------
// tb_soe_monitor
//
// Self-checking bench for soe_monitor. Two instances share all inputs:
//   - dut:   default parameters (32-bit counters);
//   - sdut:  CNT_W=4, to observe counter saturation.
// A behavioural model tracks the true (unbounded) error counts and applies
// saturation only when comparing. The run covers:
//   - directed scenarios from the test plan;
//   - a randomized phase with random starts, aborts and resets.
// -----------------------------------------------------------------------------
module tb_soe_monitor;

    localparam int W  = 2;
    localparam int CW = 32;
    localparam int NW = 32;
    localparam int SW = 4;

    localparam longint unsigned CAP_FULL = 64'h0000_0000_FFFF_FFFF;
    localparam longint unsigned CAP_SAT  = 64'd15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_cycles;
    logic [W-1:0]  mask;
    logic          obs_valid;
    logic [W-1:0]  obs;
    logic [W-1:0]  gold;
    logic          abort;

    logic            busy, done, err_seen;
    logic [NW-1:0]   soe_total;
    logic [W*NW-1:0] soe_bit;
    logic [CW-1:0]   samples, first_err;

    logic            s_busy, s_done, s_err;
    logic [SW-1:0]   s_total;
    logic [W*SW-1:0] s_bit;
    logic [CW-1:0]   s_samples, s_first;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    soe_monitor #(.WIDTH(W), .CYC_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_cycles(num_cycles),
        .mask(mask), .obs_valid(obs_valid), .obs(obs), .gold(gold),
        .abort(abort), .busy(busy), .done(done), .soe_total(soe_total),
        .soe_bit(soe_bit), .samples(samples), .first_err(first_err),
        .err_seen(err_seen)
    );

    soe_monitor #(.WIDTH(W), .CYC_W(CW), .CNT_W(SW)) sdut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_cycles(num_cycles),
        .mask(mask), .obs_valid(obs_valid), .obs(obs), .gold(gold),
        .abort(abort), .busy(s_busy), .done(s_done), .soe_total(s_total),
        .soe_bit(s_bit), .samples(s_samples), .first_err(s_first),
        .err_seen(s_err)
    );

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t         m_st;
    longint unsigned m_total;
    longint unsigned m_bit [W];
    longint unsigned m_samples;
    longint unsigned m_ncyc;
    logic [W-1:0]    m_mask;
    logic [CW-1:0]   m_first;
    logic            m_err;

    function automatic longint unsigned capv(input longint unsigned v, input longint unsigned cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic model_clear();
        m_total   = 0;
        m_samples = 0;
        m_first   = '1;
        m_err     = 1'b0;
        for (int i = 0; i < W; i++) m_bit[i] = 0;
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_ncyc = 0;
        m_mask = '0;
        model_clear();
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_update();
        logic [W-1:0] e;
        if (m_st == M_RUN) begin
            if (obs_valid) begin
                e = (obs ^ gold) & m_mask;
                if (e != '0) begin
                    if (!m_err) begin
                        m_first = m_samples[CW-1:0];
                        m_err   = 1'b1;
                    end
                    m_total++;
                    for (int i = 0; i < W; i++) if (e[i]) m_bit[i]++;
                end
                m_samples++;
            end
            if (abort)                                m_st = M_IDLE;
            else if (obs_valid && m_samples == m_ncyc) m_st = M_DONE;
        end else if (start) begin
            m_ncyc = num_cycles;
            m_mask = mask;
            model_clear();
            m_st = (num_cycles == '0) ? M_DONE : M_RUN;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("busy",      64'(busy),      64'(m_st == M_RUN));
        check_eq("done",      64'(done),      64'(m_st == M_DONE));
        check_eq("soe_total", 64'(soe_total), capv(m_total, CAP_FULL));
        for (int i = 0; i < W; i++)
            check_eq("soe_bit", 64'(soe_bit[i*NW +: NW]), capv(m_bit[i], CAP_FULL));
        check_eq("samples",   64'(samples),   m_samples);
        check_eq("first_err", 64'(first_err), 64'(m_first));
        check_eq("err_seen",  64'(err_seen),  64'(m_err));
        check_eq("s_busy",    64'(s_busy),    64'(m_st == M_RUN));
        check_eq("s_done",    64'(s_done),    64'(m_st == M_DONE));
        check_eq("s_total",   64'(s_total),   capv(m_total, CAP_SAT));
        for (int i = 0; i < W; i++)
            check_eq("s_bit", 64'(s_bit[i*SW +: SW]), capv(m_bit[i], CAP_SAT));
        check_eq("s_samples", 64'(s_samples), m_samples);
        check_eq("s_first",   64'(s_first),   64'(m_first));
    endtask

    // One clock: drive inputs, advance model, sample outputs 1 unit after the edge.
    task automatic step(input logic s, input logic [CW-1:0] n, input logic [W-1:0] mk,
                        input logic v, input logic [W-1:0] o, input logic [W-1:0] g,
                        input logic a);
        start = s; num_cycles = n; mask = mk; obs_valid = v; obs = o; gold = g; abort = a;
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic sample(input logic v, input logic [W-1:0] o, input logic [W-1:0] g, input logic a);
        step(1'b0, '0, '0, v, o, g, a);
    endtask

    task automatic do_reset();
        start = 1'b0; obs_valid = 1'b0; abort = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] g, o, fl;
        logic [CW-1:0] n;

        rst_n = 1'b1; start = 1'b0; num_cycles = '0; mask = '0;
        obs_valid = 1'b0; obs = '0; gold = '0; abort = 1'b0;
        model_reset();
        #1;
        do_reset();
        check_eq("rst_first_err", 64'(first_err), 64'h0000_0000_FFFF_FFFF);

        // Clean run of 10 samples.
        step(1'b1, 32'd10, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
        check_eq("clean_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 10; k++) begin
            g = 2'($urandom);
            sample(1'b1, g, g, 1'b0);
        end
        check_eq("clean_done",  64'(done),      64'd1);
        check_eq("clean_total", 64'(soe_total), 64'd0);
        check_eq("clean_samp",  64'(samples),   64'd10);
        check_eq("clean_first", 64'(first_err), 64'h0000_0000_FFFF_FFFF);
        check_eq("clean_seen",  64'(err_seen),  64'd0);

        // Masked bit 0: only the bit-1 flip at sample 5 counts.
        step(1'b1, 32'd8, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            g  = 2'($urandom);
            fl = {(k == 5) ? 1'b1 : 1'b0, (k == 1 || k == 4 || k == 5) ? 1'b1 : 1'b0};
            sample(1'b1, g ^ fl, g, 1'b0);
        end
        check_eq("mask_total", 64'(soe_total),        64'd1);
        check_eq("mask_bit1",  64'(soe_bit[NW +: NW]), 64'd1);
        check_eq("mask_bit0",  64'(soe_bit[0 +: NW]),  64'd0);
        check_eq("mask_first", 64'(first_err),        64'd5);

        // Gapped valid, both bits wrong on every valid sample.
        step(1'b1, 32'd4, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 7; k++) begin
            g = 2'($urandom);
            sample((k == 0 || k == 3 || k == 4 || k == 6) ? 1'b1 : 1'b0, ~g, g, 1'b0);
            if (k == 5) check_eq("gap_notdone", 64'(done), 64'd0);
        end
        check_eq("gap_done",  64'(done),               64'd1);
        check_eq("gap_total", 64'(soe_total),          64'd4);
        check_eq("gap_bit0",  64'(soe_bit[0 +: NW]),   64'd4);
        check_eq("gap_bit1",  64'(soe_bit[NW +: NW]),  64'd4);

        // Abort together with the final (erroneous) sample.
        step(1'b1, 32'd5, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) sample(1'b1, 2'b01, 2'b01, 1'b0);
        sample(1'b1, 2'b10, 2'b01, 1'b1);
        check_eq("abort_busy",  64'(busy),      64'd0);
        check_eq("abort_done",  64'(done),      64'd0);
        check_eq("abort_samp",  64'(samples),   64'd5);
        check_eq("abort_total", 64'(soe_total), 64'd1);
        sample(1'b1, 2'b10, 2'b01, 1'b1);  // abort/valid outside RUN: no effect

        // Saturation: 20 erroneous samples.
        step(1'b1, 32'd20, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 20; k++) begin
            g = 2'($urandom);
            sample(1'b1, ~g, g, 1'b0);
        end
        check_eq("sat_total",  64'(s_total),   64'd15);
        check_eq("sat_samp",   64'(s_samples), 64'd20);
        check_eq("sat_full",   64'(soe_total), 64'd20);

        // Reset mid-run, then a zero-length run.
        step(1'b1, 32'd50, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) sample(1'b1, 2'b11, 2'b00, 1'b0);
        do_reset();
        check_eq("mrst_total", 64'(soe_total), 64'd0);
        check_eq("mrst_busy",  64'(busy),      64'd0);
        step(1'b1, 32'd0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
        check_eq("zero_done",  64'(done),      64'd1);
        check_eq("zero_samp",  64'(samples),   64'd0);

        // Randomized phase.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                n  = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 24));
                g  = 2'($urandom);
                fl = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
                o  = g ^ fl;
                step(($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0, n, 2'($urandom),
                     ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, o, g,
                     ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
